// File: rtl/sha256_message_padder.sv
// Purpose     : SHA-256 front end. Packs a stream of 32-bit message words into
//               512-bit blocks and appends the 0x80 marker, zero fill and the
//               64-bit big-endian message bit length.
// Latency     : the last word at index k <= 13 (marker already placed) gives
//               block_valid_out (13 - k) + 2 cycles after its transfer. A
//               1-word message therefore takes 15 cycles.
// Backpressure: data_ready_out is low while padding, writing the length or
//               holding a block. A finished block is held stable until
//               block_ready_in is seen.
//
// Ports:
//   CLK, RST         - single rising-edge clock, synchronous active-high reset
//   data_in          - message word, byte 0 in [31:24]
//   data_valid_in    - data_in is valid
//   data_last_in     - final word of the message
//   data_bytes_in    - valid bytes in the final word minus 1 (0 => 1 byte)
//   data_ready_out   - word accepted this cycle when data_valid_in is high
//   block_out        - 512-bit block, word 0 in [511:480], word 15 in [31:0]
//   block_valid_out  - block_out holds a complete block
//   block_ready_in   - downstream takes the block (expander start pulse)
//   block_first_out  - block is the first of its message
//   block_last_out   - block is the final one and carries the length
//
// Build option: define SHA256_BYTESWAP_EN for little-endian hosts. Byte 0 is
// then taken from data_in[7:0]. Padding, length and output layout do not change.

module sha256_message_padder (
    input  logic         CLK,
    input  logic         RST,
    input  logic [31:0]  data_in,
    input  logic         data_valid_in,
    input  logic         data_last_in,
    input  logic [1:0]   data_bytes_in,
    output logic         data_ready_out,
    output logic [511:0] block_out,
    output logic         block_valid_out,
    input  logic         block_ready_in,
    output logic         block_first_out,
    output logic         block_last_out
);

    typedef enum logic [1:0] {
        S_FILL,   // accepting message words
        S_PAD,    // writing marker / zero words after the message
        S_LEN,    // writing the 64-bit length into words 14 and 15
        S_EMIT    // holding a finished block for downstream
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [63:0]  len_bits_q, len_bits_d;
    logic         pad_done_q, pad_done_d;   // 0x80 marker already written
    logic         final_q, final_d;         // current block carries the length
    logic         first_q, first_d;         // current block starts a message
    logic         msg_end_q, msg_end_d;     // last word seen, still padding
    logic [31:0]  word_q [16];
    logic [31:0]  word_d [16];

    logic         word_xfer;
    logic         blk_xfer;
    logic         word_written;
    logic [31:0]  data_w;
    logic [31:0]  keep_mask;
    logic [31:0]  marker;
    logic [2:0]   last_nbytes;

    // ------------------------------------------------------------------
    // Input byte ordering
    // ------------------------------------------------------------------
`ifdef SHA256_BYTESWAP_EN
    assign data_w = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
`else
    assign data_w = data_in;
`endif

    // The final word keeps its top b bytes. When b < 4 the marker
    // goes into the first free byte position of the same word.
    always_comb begin
        keep_mask   = 32'hFFFF_FFFF;
        marker      = 32'h0000_0000;
        last_nbytes = 3'd4;
        case (data_bytes_in)
            2'd0: begin
                keep_mask   = 32'hFF00_0000;
                marker      = 32'h0080_0000;
                last_nbytes = 3'd1;
            end
            2'd1: begin
                keep_mask   = 32'hFFFF_0000;
                marker      = 32'h0000_8000;
                last_nbytes = 3'd2;
            end
            2'd2: begin
                keep_mask   = 32'hFFFF_FF00;
                marker      = 32'h0000_0080;
                last_nbytes = 3'd3;
            end
            2'd3: begin
                keep_mask   = 32'hFFFF_FFFF;
                marker      = 32'h0000_0000;
                last_nbytes = 3'd4;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes and outputs
    // ------------------------------------------------------------------
    assign data_ready_out  = (state_q == S_FILL) && !RST;
    assign block_valid_out = (state_q == S_EMIT) && !RST;
    assign block_first_out = block_valid_out && first_q;
    assign block_last_out  = block_valid_out && final_q;

    assign word_xfer = data_valid_in && data_ready_out;
    assign blk_xfer  = block_valid_out && block_ready_in;

    // The block bus is forced to zero while reset is asserted, so a block
    // that is discarded mid-EMIT is never visible downstream.
    always_comb begin
        block_out = '0;
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                block_out[511 - 32*i -: 32] = word_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_bits_d   = len_bits_q;
        pad_done_d   = pad_done_q;
        final_d      = final_q;
        first_d      = first_q;
        msg_end_d    = msg_end_q;
        word_d       = word_q;
        word_written = 1'b0;

        case (state_q)
            S_FILL: begin
                if (word_xfer) begin
                    word_written = 1'b1;
                    idx_d        = idx_q + 5'd1;
                    if (data_last_in) begin
                        word_d[idx_q[3:0]] = (data_w & keep_mask) | marker;
                        len_bits_d = len_bits_q + {58'd0, last_nbytes, 3'b000};
                        msg_end_d  = 1'b1;
                        if (last_nbytes != 3'd4) begin
                            pad_done_d = 1'b1;
                        end
                    end else begin
                        word_d[idx_q[3:0]] = data_w;
                        len_bits_d = len_bits_q + 64'd32;
                    end
                end
            end

            S_PAD: begin
                word_written = 1'b1;
                idx_d        = idx_q + 5'd1;
                if (!pad_done_q) begin
                    word_d[idx_q[3:0]] = 32'h8000_0000;
                    pad_done_d         = 1'b1;
                end else begin
                    word_d[idx_q[3:0]] = 32'h0000_0000;
                end
            end

            S_LEN: begin
                word_d[14] = len_bits_q[63:32];
                word_d[15] = len_bits_q[31:0];
                final_d    = 1'b1;
                state_d    = S_EMIT;
            end

            S_EMIT: begin
                if (blk_xfer) begin
                    idx_d   = 5'd0;
                    first_d = final_q;
                    for (int i = 0; i < 16; i++) begin
                        word_d[i] = 32'h0000_0000;
                    end
                    if (final_q) begin
                        len_bits_d = 64'd0;
                        pad_done_d = 1'b0;
                        final_d    = 1'b0;
                        msg_end_d  = 1'b0;
                        state_d    = S_FILL;
                    end else if (msg_end_q) begin
                        // Overflow block: the length goes into the next block.
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
        endcase

        // Next state after any word write, evaluated on the new index. Once
        // the marker is in and index 14 is reached, the length fits in this
        // block. Past 14 the block is zero-filled and the length moves on.
        if (word_written) begin
            if (idx_d == 5'd16) begin
                state_d = S_EMIT;
            end else if (msg_end_d && pad_done_d && (idx_d == 5'd14)) begin
                state_d = S_LEN;
            end else if (msg_end_d) begin
                state_d = S_PAD;
            end else begin
                state_d = S_FILL;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_FILL;
            idx_q      <= 5'd0;
            len_bits_q <= 64'd0;
            pad_done_q <= 1'b0;
            final_q    <= 1'b0;
            first_q    <= 1'b1;
            msg_end_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                word_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_bits_q <= len_bits_d;
            pad_done_q <= pad_done_d;
            final_q    <= final_d;
            first_q    <= first_d;
            msg_end_q  <= msg_end_d;
            for (int i = 0; i < 16; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_message_padder.sv
// Bench for sha256_message_padder. A byte-level padding model builds the
// expected blocks, and a negedge monitor checks every block cycle against it.
`timescale 1ns/1ps
module tb_sha256_message_padder;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  data_in;
    logic         data_valid_in;
    logic         data_last_in;
    logic [1:0]   data_bytes_in;
    logic         data_ready_out;
    logic [511:0] block_out;
    logic         block_valid_out;
    logic         block_ready_in;
    logic         block_first_out;
    logic         block_last_out;

    sha256_message_padder dut (
        .CLK             (CLK),
        .RST             (RST),
        .data_in         (data_in),
        .data_valid_in   (data_valid_in),
        .data_last_in    (data_last_in),
        .data_bytes_in   (data_bytes_in),
        .data_ready_out  (data_ready_out),
        .block_out       (block_out),
        .block_valid_out (block_valid_out),
        .block_ready_in  (block_ready_in),
        .block_first_out (block_first_out),
        .block_last_out  (block_last_out)
    );

    always #5 CLK = ~CLK;

    typedef logic [7:0] bytes_t [$];
    typedef struct {
        logic [511:0] dat;
        bit           first;
        bit           last;
    } blk_t;

    blk_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] d, input int w);
        return d[511 - 32*w -: 32];
    endfunction

    function automatic bytes_t make_msg(input int n, input int seed);
        bytes_t m;
        for (int i = 0; i < n; i++) m.push_back(8'((i * 37 + seed * 11 + 1) & 255));
        return m;
    endfunction

    // Padding model: message bytes, 0x80, zeros until 56 mod 64, then the
    // 64-bit big-endian bit length. The result is cut into 64-byte blocks.
    task automatic model_blocks(input bytes_t m, output blk_t blks [$]);
        bytes_t      p;
        logic [63:0] bits;
        int          nb;
        blk_t        b;
        blks = {};
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            b.dat = '0;
            for (int j = 0; j < 64; j++) b.dat[511 - 8*j -: 8] = p[64*k + j];
            b.first = (k == 0);
            b.last  = (k == nb - 1);
            blks.push_back(b);
        end
    endtask

    // Drives the message words. Unused bytes of the last word carry garbage.
    // Returns the cycle of the final word transfer.
    task automatic send_msg(input bytes_t m, input bit end_msg, output int xc);
        int          nw;
        int          nb;
        int          waited;
        bit          done;
        logic [31:0] w;
        nw = (m.size() + 3) / 4;
        xc = -1;
        for (int k = 0; k < nw; k++) begin
            w  = 32'hA5A5_A5A5;
            nb = m.size() - 4*k;
            if (nb > 4) nb = 4;
            for (int j = 0; j < nb; j++) w[31 - 8*j -: 8] = m[4*k + j];
`ifdef SHA256_BYTESWAP_EN
            data_in = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
            data_in = w;
`endif
            data_last_in  = end_msg && (k == nw - 1);
            data_bytes_in = data_last_in ? 2'(nb - 1) : 2'(k);
            data_valid_in = 1'b1;
            done   = 1'b0;
            waited = 0;
            while (!done) begin
                @(negedge CLK);
                if (data_ready_out) begin
                    done = 1'b1;
                    xc   = cyc;
                end
                @(posedge CLK); #1;
                if (!done) begin
                    waited++;
                    if (waited > 200) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL input_timeout: got data_ready_out low for %0d cycles, required accept", waited);
                        done = 1'b1;
                    end
                end
            end
        end
        data_valid_in = 1'b0;
        data_last_in  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge CLK);
        chk("drain_pending_blocks", 512'(exp_q.size()), 512'(0));
        @(posedge CLK); #1;
    endtask

    task automatic run_msg(input bytes_t m, input int exp_lat);
        blk_t blks [$];
        int   xc;
        int   lat;
        model_blocks(m, blks);
        foreach (blks[i]) exp_q.push_back(blks[i]);
        send_msg(m, 1'b1, xc);
        if (exp_lat >= 0) begin
            lat = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge CLK);
                if (block_valid_out) begin
                    lat = cyc - xc;
                    break;
                end
            end
            chk("latency", 512'(lat), 512'(exp_lat));
        end
        drain();
    endtask

    // Monitor: every cycle a block is offered, it must match the head of the
    // expected queue. The head is consumed on a handshake.
    always @(negedge CLK) begin
        if (!RST) begin
            if (block_valid_out) begin
                chk("ready_while_block_pending", 512'(data_ready_out), 512'(0));
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_block: got block %0h, required none", block_out);
                end else begin
                    chk("block_out", block_out, exp_q[0].dat);
                    chk("block_first", 512'(block_first_out), 512'(exp_q[0].first));
                    chk("block_last", 512'(block_last_out), 512'(exp_q[0].last));
                    if (block_ready_in) void'(exp_q.pop_front());
                end
            end else begin
                chk("first_idle", 512'(block_first_out), 512'(0));
                chk("last_idle", 512'(block_last_out), 512'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t abc;
        bytes_t m;
        blk_t   blks [$];
        int     xc;
        int     lens [] = '{1, 2, 4, 5, 7, 8, 52, 57, 58, 59, 60, 61, 63, 65, 119, 120, 128};

        RST            = 1'b1;
        data_in        = '0;
        data_valid_in  = 1'b0;
        data_last_in   = 1'b0;
        data_bytes_in  = '0;
        block_ready_in = 1'b1;
        abc = '{8'h61, 8'h62, 8'h63};

        // Reset behaviour
        @(negedge CLK);
        chk("rst_ready", 512'(data_ready_out), 512'(0));
        chk("rst_valid", 512'(block_valid_out), 512'(0));
        chk("rst_block", block_out, 512'(0));
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", 512'(data_ready_out), 512'(1));
        chk("post_rst_valid", 512'(block_valid_out), 512'(0));
        chk("post_rst_block", block_out, 512'(0));
        chk("post_rst_first", 512'(block_first_out), 512'(0));
        chk("post_rst_last", 512'(block_last_out), 512'(0));
        @(posedge CLK); #1;

        // "abc": pin the model, then run it
        model_blocks(abc, blks);
        chk("model_abc_nblk", 512'(blks.size()), 512'(1));
        chk("model_abc_w0", 512'(word_of(blks[0].dat, 0)), 512'(32'h6162_6380));
        chk("model_abc_w15", 512'(word_of(blks[0].dat, 15)), 512'(32'h0000_0018));
        for (int w = 1; w < 15; w++) chk("model_abc_zero", 512'(word_of(blks[0].dat, w)), 512'(0));
        run_msg(abc, 15);

        // 55 bytes: marker in word 13, single block, length 440
        m = make_msg(55, 1);
        model_blocks(m, blks);
        chk("model_55_nblk", 512'(blks.size()), 512'(1));
        chk("model_55_marker", 512'(word_of(blks[0].dat, 13) & 32'hFF), 512'(32'h80));
        chk("model_55_w15", 512'(word_of(blks[0].dat, 15)), 512'(32'h0000_01B8));
        run_msg(m, 2);

        // 56 bytes: overflow block then length-only block
        m = make_msg(56, 2);
        model_blocks(m, blks);
        chk("model_56_nblk", 512'(blks.size()), 512'(2));
        chk("model_56_b1w14", 512'(word_of(blks[0].dat, 14)), 512'(32'h8000_0000));
        chk("model_56_b1w15", 512'(word_of(blks[0].dat, 15)), 512'(0));
        chk("model_56_b2w0", 512'(word_of(blks[1].dat, 0)), 512'(0));
        chk("model_56_b2w15", 512'(word_of(blks[1].dat, 15)), 512'(32'h0000_01C0));
        run_msg(m, -1);

        // 64 bytes: raw data block, then marker + length block
        m = make_msg(64, 3);
        model_blocks(m, blks);
        chk("model_64_b2w0", 512'(word_of(blks[1].dat, 0)), 512'(32'h8000_0000));
        chk("model_64_b2w15", 512'(word_of(blks[1].dat, 15)), 512'(32'h0000_0200));
        run_msg(m, -1);

        // Assorted lengths covering every final-word byte count and the
        // boundary indices 13..15
        foreach (lens[i]) begin
            m = make_msg(lens[i], i + 10);
            run_msg(m, -1);
        end
        m = make_msg(5, 4);
        run_msg(m, 14);

        // Backpressure: hold the block for 20 cycles
        block_ready_in = 1'b0;
        model_blocks(abc, blks);
        foreach (blks[i]) exp_q.push_back(blks[i]);
        send_msg(abc, 1'b1, xc);
        for (int i = 0; i < 60 && !block_valid_out; i++) @(negedge CLK);
        repeat (20) begin
            @(negedge CLK);
            chk("bp_valid_held", 512'(block_valid_out), 512'(1));
            chk("bp_no_input", 512'(data_ready_out), 512'(0));
            chk("bp_not_consumed", 512'(exp_q.size()), 512'(1));
        end
        @(posedge CLK); #1;
        block_ready_in = 1'b1;
        @(negedge CLK);
        chk("bp_valid_at_accept", 512'(block_valid_out), 512'(1));
        @(negedge CLK);
        chk("bp_valid_after_accept", 512'(block_valid_out), 512'(0));
        chk("bp_ready_after_accept", 512'(data_ready_out), 512'(1));
        chk("bp_consumed", 512'(exp_q.size()), 512'(0));
        @(posedge CLK); #1;

        // Reset mid-FILL after 5 words, then "abc"
        m = make_msg(20, 7);
        send_msg(m, 1'b0, xc);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        run_msg(abc, 15);

        // Reset mid-EMIT discards the held block
        block_ready_in = 1'b0;
        model_blocks(abc, blks);
        foreach (blks[i]) exp_q.push_back(blks[i]);
        send_msg(abc, 1'b1, xc);
        for (int i = 0; i < 60 && !block_valid_out; i++) @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        chk("emit_rst_valid", 512'(block_valid_out), 512'(0));
        chk("emit_rst_ready", 512'(data_ready_out), 512'(0));
        chk("emit_rst_block", block_out, 512'(0));
        chk("emit_rst_last", 512'(block_last_out), 512'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        block_ready_in = 1'b1;
        repeat (40) @(negedge CLK);
        chk("no_block_after_rst", 512'(block_valid_out), 512'(0));
        @(posedge CLK); #1;
        run_msg(abc, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_message_padder.md
# sha256_message_padder

Front end of the SHA-256 datapath: accepts a message as a stream of 32-bit words, applies standard SHA-256 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and assembles 512-bit blocks for the message expansion stage. Each block is presented with a valid/ready handshake. The integrator ties `block_ready_in` to "expansion FSM idle" and uses the accept cycle as the expander's start pulse. Messages of 1 byte or more are supported; zero-length messages are not.

## Interface
- No parameters.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `data_in` in 32: message word; byte 0 of the word is in [31:24].
- `data_valid_in` in 1: `data_in` is valid.
- `data_last_in` in 1: this is the final word of the message.
- `data_bytes_in` in 2: valid bytes in the final word, minus 1 (0 means 1 byte, 3 means 4 bytes); ignored unless `data_last_in` is high.
- `data_ready_out` out 1: the padder accepts a word this cycle.
- `block_out` out 512: word 0 in [511:480], word 15 in [31:0].
- `block_valid_out` out 1: `block_out` holds a complete block.
- `block_ready_in` in 1: downstream accepts the block.
- `block_first_out` out 1: the block is the first block of its message.
- `block_last_out` out 1: the block is the final block (it carries the length).

## Operation
- State: `state` ∈ {FILL, PAD, LEN, EMIT}; `idx` (5 bits, 0..16); 64-bit `len_bits`; flags `pad_done`, `final`, `first`; 16×32 word registers.
- A word transfers when `data_valid_in` && `data_ready_out`. `data_ready_out` = (state == FILL) && !`RST`.
- A block transfers when `block_valid_out` && `block_ready_in`. `block_valid_out` = (state == EMIT).
- FILL, non-last transfer: word[idx] ← data; idx++; `len_bits` += 32.
- FILL, last transfer with b = `data_bytes_in` + 1 valid bytes: keep the top b bytes and zero the rest.
  - If b < 4: byte position b ← 0x80 and `pad_done` ← 1.
  - `len_bits` += 8·b; idx++.
- PAD: if !`pad_done`, word[idx] ← 0x80000000 and `pad_done` ← 1; otherwise word[idx] ← 0. Then idx++.
- LEN: word14 ← `len_bits`[63:32]; word15 ← `len_bits`[31:0]; `final` ← 1; go to EMIT.
- Next-state rule after any word write, with n = new idx, evaluated in this order:
  1. n == 16 → EMIT.
  2. else if the message is in padding and `pad_done` && n == 14 → LEN.
  3. else if the message is in padding → PAD.
  4. else → FILL.
- EMIT holds all outputs stable until a block transfer. On transfer:
  - idx ← 0 and all word registers cleared.
  - `first` ← `final`.
  - If `final`: clear `len_bits`, `pad_done` and `final`, go to FILL.
  - Else if still in padding: go to PAD.
  - Else: go to FILL.
- `block_first_out` = `first` and `block_last_out` = `final`, both qualified by EMIT; both read 0 otherwise.
- `len_bits` wraps modulo 2^64.
- If padding reaches idx 14 or 15 with `pad_done` still 0, or with `pad_done` 1 past idx 14, the current block is zero-filled to 16 words and emitted non-final. The next block is zero-filled through word 13, then LEN.

## Timing
- Reset (RST high at a rising edge):
  - state ← FILL, idx ← 0, `len_bits` ← 0, flags ← 0, `first` ← 1, words ← 0.
  - Outputs during and after reset: `block_out` = 0, `block_valid_out` = 0, `block_first_out` = 0, `block_last_out` = 0.
  - `data_ready_out` = 0 while RST is high.
- Reset mid-message or mid-EMIT discards all partial state; there is no block output afterwards.
- Throughput: one input word per cycle in FILL. PAD writes one word per cycle. LEN takes 1 cycle.
- Latency from the last-word transfer in cycle t, with the marker placed and the last word at idx k ≤ 13: `block_valid_out` rises at t + (13 − k) + 2.
- Example: a 1-word message gives `block_valid_out` at t+15.
- `data_ready_out` is 0 in PAD, LEN and EMIT. Input is never accepted while a block is pending.
- Block transfer at cycle t → the next state is active at t+1. `data_ready_out` can be 1 at t+1.

## Configuration
- `SHA256_BYTESWAP_EN`:
  - Defined: `data_in` is byte-reversed before storage, so byte 0 is taken from [7:0] (little-endian host). `data_bytes_in` still counts bytes from byte 0.
  - Undefined: words are stored as received (big-endian).
  - Padding, length and output layout are identical in both builds.

## Test plan
- "abc": `data_in` = 0x61626300, last, bytes = 2 → one block. Word0 = 0x61626380, words 1–14 = 0, word15 = 0x00000018. first = last = 1. `block_valid_out` 15 cycles after the transfer.
- 55 bytes (13 full words + last word with bytes = 2): word13 low byte = 0x80, word15 = 0x000001B8, single block with first = last = 1.
- 56 bytes (14 full words, last word full): block 1 has word14 = 0x80000000, word15 = 0, first = 1, last = 0. Block 2 has words 0–14 = 0, word15 = 0x000001C0, first = 0, last = 1.
- 64 bytes: block 1 is raw data (last = 0). Block 2 has word0 = 0x80000000 and word15 = 0x00000200.
- Backpressure: hold `block_ready_in` = 0 for 20 cycles in EMIT. `block_out` stays stable, `data_ready_out` stays 0, and the block transfers on the first cycle ready = 1.
- Reset mid-FILL after 5 words, then send "abc": the output is identical to the first scenario. With `SHA256_BYTESWAP_EN`, `data_in` = 0x00636261 gives the same block.
